// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the sequential ALU.
// Op encodings and the two-state controller enum.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_NOTB = 3'b011,
    OP_MUL  = 3'b100,
    OP_LSL  = 3'b101,
    OP_LSR  = 3'b110,
    OP_ASR  = 3'b111
  } alu_op_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_comb_core.sv
// alu_comb_core: single-cycle ALU ops plus Z/N/V.
// Ports: i_ain, i_bin, i_op in; o_res, o_z, o_n, o_v out.
module alu_comb_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_ain,
  input  logic [WIDTH-1:0] i_bin,
  input  alu_op_t          i_op,
  output logic [WIDTH-1:0] o_res,
  output logic             o_z,
  output logic             o_n,
  output logic             o_v
);

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH:0]   w_sum;
  logic             w_c_msb;

  // SUB is A + ~B + 1, sharing the adder with ADD
  assign w_is_sub = (i_op == OP_SUB);
  assign w_b      = w_is_sub ? ~i_bin : i_bin;
  assign w_sum    = {1'b0, i_ain} + {1'b0, w_b}
                  + {{WIDTH{1'b0}}, w_is_sub};
  // carry into the MSB, recovered from the MSB sum bit
  assign w_c_msb  = i_ain[WIDTH-1] ^ w_b[WIDTH-1]
                  ^ w_sum[WIDTH-1];

  always_comb begin
    o_res = '0;
    o_v   = 1'b0;
    unique case (i_op)
      OP_ADD, OP_SUB: begin
        o_res = w_sum[WIDTH-1:0];
        o_v   = w_c_msb ^ w_sum[WIDTH];
      end
      OP_AND:  o_res = i_ain & i_bin;
      OP_NOTB: o_res = ~i_bin;
      OP_MUL:  o_res = '0;
      OP_LSL:  o_res = {i_ain[WIDTH-2:0], 1'b0};
      OP_LSR:  o_res = {1'b0, i_ain[WIDTH-1:1]};
      OP_ASR:  o_res = {i_ain[WIDTH-1], i_ain[WIDTH-1:1]};
    endcase
  end

  assign o_z = ~|o_res;
  assign o_n = o_res[WIDTH-1];

endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU, 1-cycle ops and shift-add MUL.
// Ports: valid/ready op input, out_valid pulse, cout + Z/N/V.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] ain,
  input  logic [WIDTH-1:0] bin,
  input  logic [2:0]       alu_op,
  output logic             out_valid,
  output logic [WIDTH-1:0] cout,
  output logic             status_z,
  output logic             status_n,
  output logic             status_v
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  alu_state_t         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_cout;
  logic               r_z;
  logic               r_n;
  logic               r_v;

  alu_op_t            w_op;
  logic               w_accept;
  logic [2*WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0]   w_res;
  logic               w_z;
  logic               w_n;
  logic               w_v;

  assign w_op     = alu_op_t'(alu_op);
  assign in_ready = (r_state == S_IDLE);
  assign w_accept = in_valid & in_ready;

  // accumulator value after this BUSY step
  assign w_acc_nxt = r_acc
                   + (r_mplier[0] ? r_mcand : '0);

  alu_comb_core #(.WIDTH(WIDTH)) u_core (
    .i_ain (ain),
    .i_bin (bin),
    .i_op  (w_op),
    .o_res (w_res),
    .o_z   (w_z),
    .o_n   (w_n),
    .o_v   (w_v)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_mcand     <= '0;
      r_acc       <= '0;
      r_mplier    <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_cout      <= '0;
      r_z         <= 1'b0;
      r_n         <= 1'b0;
      r_v         <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == OP_MUL) begin
              r_mcand  <= {{WIDTH{1'b0}}, ain};
              r_mplier <= bin;
              r_acc    <= '0;
              r_cnt    <= '0;
              r_state  <= S_BUSY;
            end else begin
              r_out_valid <= 1'b1;
              r_cout      <= w_res;
              r_z         <= w_z;
              r_n         <= w_n;
              r_v         <= w_v;
            end
          end
        end
        S_BUSY: begin
          r_acc    <= w_acc_nxt;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_out_valid <= 1'b1;
            r_cout      <= w_acc_nxt[WIDTH-1:0];
            r_z         <= ~|w_acc_nxt[WIDTH-1:0];
            r_n         <= w_acc_nxt[WIDTH-1];
            r_v         <= |w_acc_nxt[2*WIDTH-1:WIDTH];
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign cout      = r_cout;
  assign status_z  = r_z;
  assign status_n  = r_n;
  assign status_v  = r_v;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: scoreboard bench for alu_seq at WIDTH=16.
// Tasks drive ops; a monitor pops expectations on out_valid.
module tb_alu_seq;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] ain;
  logic [W-1:0] bin;
  logic [2:0]   alu_op;
  logic         out_valid;
  logic [W-1:0] cout;
  logic         status_z;
  logic         status_n;
  logic         status_v;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         v;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  alu_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ain       (ain),
    .bin       (bin),
    .alu_op    (alu_op),
    .out_valid (out_valid),
    .cout      (cout),
    .status_z  (status_z),
    .status_n  (status_n),
    .status_v  (status_v)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // reference: signed-overflow rules, full product for MUL
  function automatic exp_t model(input logic [2:0] op,
                                 input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t         m;
    logic [2*W-1:0] p;
    m.res = '0;
    m.v   = 1'b0;
    p     = '0;
    case (op)
      3'd0: begin
        m.res = a + b;
        m.v = (a[W-1] == b[W-1]) && (m.res[W-1] != a[W-1]);
      end
      3'd1: begin
        m.res = a - b;
        m.v = (a[W-1] != b[W-1]) && (m.res[W-1] != a[W-1]);
      end
      3'd2: m.res = a & b;
      3'd3: m.res = ~b;
      3'd4: begin
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        m.res = p[W-1:0];
        m.v = |p[2*W-1:W];
      end
      3'd5: m.res = a << 1;
      3'd6: m.res = a >> 1;
      default: m.res = {a[W-1], a[W-1:1]};
    endcase
    m.z   = (m.res == '0);
    m.n   = m.res[W-1];
    m.cyc = 0;
    return m;
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid cout=%h", cout);
      end else begin
        e = q.pop_front();
        if (cout !== e.res) begin
          n_bad++;
          $display("FAIL cout got=%h exp=%h", cout, e.res);
        end
        n_cmp++;
        if ({status_z, status_n, status_v} !==
            {e.z, e.n, e.v}) begin
          n_bad++;
          $display("FAIL flags_znv got=%b%b%b exp=%b%b%b",
                   status_z, status_n, status_v,
                   e.z, e.n, e.v);
        end
        n_cmp++;
        if (cyc !== e.cyc) begin
          n_bad++;
          $display("FAIL latency got_cyc=%0d exp_cyc=%0d",
                   cyc, e.cyc);
        end
      end
    end
  end

  // call at a negedge; returns at the negedge after accept
  // with in_valid still high
  task automatic send(input logic [2:0] op,
                      input logic [W-1:0] a,
                      input logic [W-1:0] b);
    exp_t m;
    int   w;
    w = 0;
    in_valid = 1'b1;
    alu_op   = op;
    ain      = a;
    bin      = b;
    while (!in_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout in_ready=%b exp=1", in_ready);
    end
    m = model(op, a, b);
    m.cyc = cyc + 1 + ((op == 3'd4) ? W : 0);
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, status_z, status_n, status_v} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs ov=%b cout=%h znv=%b%b%b exp=0",
               out_valid, cout, status_z, status_n, status_v);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got=%b exp=1", in_ready);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add_sub();
    send(3'd0, 16'h7FFF, 16'h0001);
    send(3'd1, 16'h8000, 16'h0001);
    send(3'd1, 16'h1234, 16'h1234);
    send(3'd2, 16'h00C0, 16'h00C0);
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_bits();
    logic [W-1:0] v;
    for (int i = 0; i < W; i++) begin
      v = '0;
      v[i] = 1'b1;
      send(3'd2, v, v);
    end
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_shifts();
    send(3'd7, 16'h8002, 16'h0000);
    send(3'd6, 16'h8002, 16'h0000);
    send(3'd5, 16'h8001, 16'h0000);
    send(3'd3, 16'h1234, 16'hFFFF);
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mul();
    int n;
    send(3'd4, 16'h0003, 16'h0005);
    idle();
    n = 0;
    while (!in_ready && n < 40) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== W) begin
      n_bad++;
      $display("FAIL mul_busy_cycles got=%0d exp=%0d", n, W);
    end
    send(3'd4, 16'h0100, 16'h0100);
    send(3'd4, 16'hABCD, 16'h1234);
    idle();
    repeat (W + 2) @(negedge clk);
  endtask

  task automatic test_mul_hold();
    int w;
    send(3'd4, 16'h7F3B, 16'h00E5);
    w = 0;
    while (!in_ready && w < 40) begin
      ain    = W'($urandom);
      bin    = W'($urandom);
      alu_op = 3'($urandom);
      @(negedge clk);
      w++;
    end
    idle();
    n_cmp++;
    if (w !== W) begin
      n_bad++;
      $display("FAIL hold_busy_cycles got=%0d exp=%0d", w, W);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    send(3'd0, 16'h1111, 16'h2222);
    send(3'd0, 16'hFFFF, 16'h0001);
    send(3'd1, 16'h0005, 16'h0007);
    idle();
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    send(3'd0, 16'h7FFF, 16'h0001);
    send(3'd4, 16'h0003, 16'h0005);
    idle();
    repeat (4) @(negedge clk);
    // the MUL is aborted, so its expectation is dropped
    void'(q.pop_back());
    reset = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({out_valid, cout, status_z, status_n, status_v} !== '0) begin
      n_bad++;
      $display("FAIL abort_outputs ov=%b cout=%h znv=%b%b%b exp=0",
               out_valid, cout, status_z, status_n, status_v);
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_in_ready got=%b exp=1", in_ready);
    end
    reset = 1'b0;
    repeat (W + 4) @(negedge clk);
    send(3'd0, 16'h0001, 16'h0001);
    idle();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    ain      = '0;
    bin      = '0;
    alu_op   = '0;
    test_reset();
    test_add_sub();
    test_single_bits();
    test_shifts();
    test_mul();
    test_mul_hold();
    test_back_to_back();
    test_reset_mid_mul();
    for (int k = 0; k < 100 && q.size() != 0; k++)
      @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL missing_results pending=%0d exp=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
